// File: rtl/m2s_fifo_pkg.sv
// Shared constants for the Avalon-MM to Avalon-ST transmit FIFO.
// Default sizes, MM register map and control bit positions.
package m2s_fifo_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int CTRL_FLUSH = 0;

endpackage

// File: rtl/m2s_fifo_ffta_ring.sv
// Register-array synchronous FIFO with show-ahead output and a synchronous flush.
// The caller guarantees push only when not full and pop only when not empty.
module m2s_fifo_ffta_ring #(
  parameter int DATA_W = m2s_fifo_pkg::DATA_W,
  parameter int DEPTH  = m2s_fifo_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // NOTE: storage is left out of reset; emptiness is tracked by level alone.
  always_ff @(posedge wrclock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge wrclock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  a_level_bound: assert property (@(posedge wrclock) disable iff (reset) level <= DEPTH_L);
  a_no_underflow: assert property (@(posedge wrclock) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/m2s_fifo_ffta.sv
// Avalon-MM write slave feeding an Avalon-ST source through a 64-entry FIFO.
// Address 0 pushes data; address 1 reads the fill level and accepts a flush command.
module m2s_fifo_ffta
  import m2s_fifo_pkg::*;
#(
  parameter int DATA_W = m2s_fifo_pkg::DATA_W,
  parameter int DEPTH  = m2s_fifo_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic              avalonmm_write_slave_address,
  input  logic              avalonmm_write_slave_write,
  input  logic [DATA_W-1:0] avalonmm_write_slave_writedata,
  input  logic              avalonmm_write_slave_read,
  output logic [DATA_W-1:0] avalonmm_write_slave_readdata,
  output logic              avalonmm_write_slave_waitrequest,
  output logic [DATA_W-1:0] avalonst_source_data,
  output logic              avalonst_source_valid,
  input  logic              avalonst_source_ready
);

  logic            data_sel;
  logic            ctrl_sel;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] level;

  assign data_sel = (avalonmm_write_slave_address == ADDR_DATA);
  assign ctrl_sel = (avalonmm_write_slave_address == ADDR_CTRL);

  assign push  = avalonmm_write_slave_write && data_sel && !full && !reset;
  assign flush = avalonmm_write_slave_write && ctrl_sel
                 && avalonmm_write_slave_writedata[CTRL_FLUSH] && !reset;
  assign pop   = avalonst_source_valid && avalonst_source_ready;

  // A full FIFO stalls data writes even when a pop lands in the same cycle.
  assign avalonmm_write_slave_waitrequest =
    reset || (avalonmm_write_slave_write && data_sel && full);

  assign avalonmm_write_slave_readdata =
    (avalonmm_write_slave_read && ctrl_sel && !reset)
      ? {{(DATA_W - ADDR_W - 1){1'b0}}, level}
      : '0;

  // Masking valid during reset also discards any pop coinciding with it.
  assign avalonst_source_valid = !empty && !reset;

  m2s_fifo_ffta_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ring (
    .wrclock (wrclock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (avalonmm_write_slave_writedata),
    .dout    (avalonst_source_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_m2s_fifo_ffta.sv
// Self-checking bench for m2s_fifo_ffta against a queue-based reference model.
// Every cycle the outputs are compared with the model before the model advances.
module tb_m2s_fifo_ffta;
  import m2s_fifo_pkg::*;

  logic        wrclock = 1'b0;
  logic        reset;
  logic        address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];

  always #5 wrclock = ~wrclock;

  m2s_fifo_ffta dut (
    .wrclock                          (wrclock),
    .reset                            (reset),
    .avalonmm_write_slave_address     (address),
    .avalonmm_write_slave_write       (write),
    .avalonmm_write_slave_writedata   (writedata),
    .avalonmm_write_slave_read        (read),
    .avalonmm_write_slave_readdata    (readdata),
    .avalonmm_write_slave_waitrequest (waitrequest),
    .avalonst_source_data             (data),
    .avalonst_source_valid            (valid),
    .avalonst_source_ready            (ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs with the model, then advance the model.
  task automatic step();
    logic exp_valid, exp_wait, do_push, do_pop, do_flush;
    @(negedge wrclock);
    exp_valid = !reset && (q.size() != 0);
    exp_wait  = reset || (write && address == ADDR_DATA && q.size() == DEPTH);
    check("valid", 32'(valid), 32'(exp_valid));
    if (exp_valid) check("data", data, q[0]);
    check("waitrequest", 32'(waitrequest), 32'(exp_wait));
    check("readdata", readdata,
          (read && address == ADDR_CTRL && !reset) ? 32'(q.size()) : 32'd0);

    do_pop   = exp_valid && ready;
    do_push  = !reset && write && address == ADDR_DATA && q.size() < DEPTH;
    do_flush = !reset && write && address == ADDR_CTRL && writedata[CTRL_FLUSH];
    if (reset) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_flush) q.delete();
      if (do_push) q.push_back(writedata);
    end
    @(posedge wrclock);
    #1;
  endtask

  task automatic idle(input int n);
    write = 1'b0;
    read  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_word(input logic [31:0] w);
    address   = ADDR_DATA;
    write     = 1'b1;
    writedata = w;
    step();
    write = 1'b0;
  endtask

  task automatic read_level();
    address = ADDR_CTRL;
    write   = 1'b0;
    read    = 1'b1;
    step();
    read    = 1'b0;
    address = ADDR_DATA;
  endtask

  task automatic ctrl_write(input logic [31:0] w);
    address   = ADDR_CTRL;
    write     = 1'b1;
    writedata = w;
    step();
    write   = 1'b0;
    address = ADDR_DATA;
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    ready = 1'b0;
    for (int i = 0; i < n; i++) push_word(base + 32'(i));
  endtask

  task automatic drain();
    ready = 1'b1;
    idle(DEPTH + 4);
    read_level();
  endtask

  initial begin
    reset = 1'b1; address = ADDR_DATA; write = 1'b0; writedata = '0;
    read = 1'b0; ready = 1'b0;
    #1;
    read_level();
    idle(2);
    reset = 1'b0;
    read_level();

    // Basic stream
    ready = 1'b1;
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    idle(4);
    read_level();

    // Fill to full, then stall until one ready pulse frees a slot
    fill(DEPTH, 32'd0);
    read_level();
    address = ADDR_DATA; write = 1'b1; writedata = 32'hCAFE_0040;
    for (int i = 0; i < 3; i++) step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    step();
    write = 1'b0;
    read_level();
    ctrl_write(32'hFFFF_FFFE);
    read_level();
    drain();

    // Simultaneous push/pop across pointer wrap
    fill(10, 32'h1000_0000);
    ready = 1'b1; address = ADDR_DATA; write = 1'b1;
    for (int i = 0; i < 100; i++) begin
      writedata = 32'h2000_0000 + 32'(i);
      step();
    end
    write = 1'b0; ready = 1'b0;
    read_level();
    drain();

    // Random traffic with pseudo-random backpressure and occasional status reads
    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        address = ADDR_CTRL; write = 1'b0; read = 1'b1;
      end else begin
        address = ADDR_DATA; read = 1'b0;
        write = ($urandom_range(0, 3) != 0);
        writedata = $urandom;
      end
      step();
    end
    read = 1'b0; write = 1'b0;
    drain();

    // Flush while a pop is in flight
    fill(20, 32'h3000_0000);
    read_level();
    ready = 1'b1;
    ctrl_write(32'h0000_0001);
    read_level();
    push_word(32'hABCD_0001);
    ready = 1'b0;
    idle(1);
    read_level();
    drain();

    // Reset mid-stream with coincident push and pop attempts
    fill(30, 32'h4000_0000);
    reset = 1'b1; ready = 1'b1; address = ADDR_DATA; write = 1'b1;
    writedata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0; write = 1'b0;
    read_level();
    push_word(32'h5555_0001);
    push_word(32'h5555_0002);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
